uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Command-driven initiator for the on-chip register bus that the GPIO and UART slaves answer on. It takes a byte stream from a UART receiver, parses read and write frames, and issues single bus transactions. It samples the slave's read data and error flag, then returns a status byte, plus data for reads, on a byte-stream transmit handshake. It sits between the UART byte RX/TX and the slave address decode, so a host PC can poke peripherals.

## Interface
- TIMEOUT_CYCLES, 100000: maximum idle cycles between bytes of one frame before the frame is aborted; must be ≥ 2.
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_RxByte  in  8  received byte, valid when i_RxValid
- i_RxValid  in  1  one-cycle pulse per received byte; no backpressure
- o_TxByte  out  8  response byte
- o_TxValid  out  1  response byte valid; held until accepted
- i_TxReady  in  1  transmitter accepts o_TxByte when o_TxValid && i_TxReady
- o_WEnable  out  1  bus write strobe, one cycle
- o_WAddr  out  32  bus write address
- o_WData  out  32  bus write data
- o_REnable  out  1  bus read strobe, one cycle
- o_RAddr  out  32  bus read address
- i_RData  in  32  slave read data, registered by slave
- i_Err  in  1  slave error flag, registered by slave
- o_Busy  out  1  high in every state except IDLE
- o_Overrun  out  1  one-cycle pulse when an incoming byte is dropped

## Operation
- Frame formats:
  - Write: 0x57 ('W'), 4 address bytes MSB first, 4 data bytes MSB first.
  - Read: 0x52 ('R'), 4 address bytes MSB first.
- Status codes: 0x4B 'K' ok; 0x45 'E' slave error; 0x3F '?' unknown command.
- States: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_STATUS, RESP_DATA.
- IDLE:
  - 'W' or 'R' latches the command and goes to ADDR.
  - Any other byte latches status 0x3F and goes to RESP_STATUS.
- ADDR: shifts 4 bytes into the address register (addr <= {addr[23:0], byte}). After the 4th byte it goes to DATA for a write, or BUS_REQ for a read.
- DATA: shifts 4 bytes into the data register the same way. After the 4th byte it goes to BUS_REQ.
- BUS_REQ: pulses o_WEnable (write) or o_REnable (read) for exactly one cycle, then goes to BUS_WAIT.
- BUS_WAIT: captures i_Err, and for a read i_RData, into internal registers. Status becomes 0x45 if i_Err, else 0x4B. Goes to RESP_STATUS.
- RESP_STATUS: drives the status byte.
  - On handshake after a read with a non-0x3F status, goes to RESP_DATA.
  - Otherwise goes to IDLE.
- RESP_DATA: sends the 4 captured read-data bytes MSB first. After the 4th handshake it goes to IDLE. Data is sent even when the status is 0x45.
- o_WAddr and o_RAddr are both driven from the single address register. o_WData is driven from the data register. All three are held stable between frames.
- Byte counter is 2 bits and wraps naturally; the transition out of ADDR or DATA happens on count 3.
- Timeout:
  - Counter clears on every accepted byte and counts only in ADDR and DATA.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no response and no bus access.
- i_RxValid in BUS_REQ, BUS_WAIT, RESP_STATUS or RESP_DATA: the byte is dropped and o_Overrun pulses the next cycle.

## Timing
- Reset values: all outputs 0; FSM in IDLE; address, data, capture and counter registers 0.
- Reset mid-frame or mid-response returns to IDLE next cycle and deasserts o_TxValid, even if a handshake is pending.
- Cycle numbering, with the final frame byte accepted at cycle N:
  - N+1: BUS_REQ, strobe high.
  - N+2: BUS_WAIT, i_RData and i_Err sampled.
  - N+3: o_TxValid high with the status byte.
- Unknown command at cycle N: o_TxValid high at N+1.
- o_TxByte is stable while o_TxValid && !i_TxReady. After a handshake, the next byte's o_TxValid rises the following cycle, so there is one idle cycle between bytes.
- i_RxValid on the same cycle the timeout fires: the timeout wins and the byte is dropped silently, with no o_Overrun.
- o_Busy is registered and rises the cycle after the command byte.

## Structure
- Package uart_bus_master_pkg holds:
  - the state enum;
  - CMD_WRITE = 8'h57 and CMD_READ = 8'h52;
  - STS_OK = 8'h4B, STS_ERR = 8'h45 and STS_BADCMD = 8'h3F.
- One sub-module, frame_timeout: a parameterised counter with inputs clear and enable, and a one-cycle expired output.

## Test plan
- Write frame 57 00 00 00 01 00 00 00 0F → o_WEnable high for one cycle with o_WAddr = 0x1 and o_WData = 0xF; response byte 0x4B; GPIO slave pin direction updated.
- Read frame 52 00 00 00 00 with the slave returning 0x000000A5 → o_REnable pulses once; response 4B 00 00 00 A5 with a 3-cycle latency to the first o_TxValid.
- Read from an unmapped address with i_Err = 1 → response 45 followed by 4 data bytes.
- Byte 0x33 in IDLE → response 0x3F only and no bus strobe. Separately, send 52 00 then stall TIMEOUT_CYCLES cycles → back in IDLE, no strobe, o_Busy = 0.
- Hold i_TxReady low for 20 cycles mid-response and inject an Rx byte → o_TxByte stays stable and o_Overrun pulses once. Asserting i_Rst mid-response clears o_TxValid the next cycle.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - shared types and constants for the UART bus master
// Purpose: FSM state encoding, command bytes and response status codes used by
// uart_bus_master and its testbench.
package uart_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP_STATUS,
    ST_RESP_DATA
  } state_e;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;

  localparam logic [7:0] STS_OK      = 8'h4B;
  localparam logic [7:0] STS_ERR     = 8'h45;
  localparam logic [7:0] STS_BADCMD  = 8'h3F;

endpackage

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte idle counter for frame abort
// Purpose: counts idle cycles while enabled; expired is high for the cycle in
// which the count sits at TIMEOUT_CYCLES-1 (the FSM leaves the counting states
// on that cycle, so it is a single-cycle pulse in practice).
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  restart count from zero (accepted byte or not in a frame)
//   enable  in  count this cycle
//   expired out limit reached; not masked by clear so it beats a same-cycle byte
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-stream to register-bus initiator
// Purpose: parses 'W'/'R' frames from the RX byte stream, issues one bus
// transaction per frame and answers with a status byte (plus 4 data bytes for
// reads) on the TX byte handshake.
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_RxByte, i_RxValid     received byte stream (no backpressure)
//   o_TxByte, o_TxValid,
//   i_TxReady               response byte stream
//   o_WEnable/o_WAddr/o_WData  bus write strobe and payload
//   o_REnable/o_RAddr       bus read strobe and address
//   i_RData, i_Err          registered slave response
//   o_Busy                  not idle
//   o_Overrun               pulse when a byte arrives while we cannot take it
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [7:0]  i_RxByte,
  input  logic        i_RxValid,
  output logic [7:0]  o_TxByte,
  output logic        o_TxValid,
  input  logic        i_TxReady,
  output logic        o_WEnable,
  output logic [31:0] o_WAddr,
  output logic [31:0] o_WData,
  output logic        o_REnable,
  output logic [31:0] o_RAddr,
  input  logic [31:0] i_RData,
  input  logic        i_Err,
  output logic        o_Busy,
  output logic        o_Overrun
);

  state_e      state_q, state_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic in_frame;
  logic tmo_expired;
  logic tx_fire;
  logic [7:0] tx_byte;

  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign tx_fire  = tx_valid_q && i_TxReady;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_Clk),
    .rst    (i_Rst),
    .clear  (i_RxValid || !in_frame),
    .enable (in_frame),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_rd_d   = cmd_rd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (i_RxValid) begin
          cnt_d = 2'd0;
          if ((i_RxByte == CMD_WRITE) || (i_RxByte == CMD_READ)) begin
            cmd_rd_d = (i_RxByte == CMD_READ);
            state_d  = ST_ADDR;
          end else begin
            status_d   = STS_BADCMD;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP_STATUS;
          end
        end
      end
      ST_ADDR: begin
        // Timeout takes priority: a byte landing on the expiry cycle is discarded.
        if (tmo_expired) begin
          state_d = ST_IDLE;
        end else if (i_RxValid) begin
          addr_d = {addr_q[23:0], i_RxByte};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = cmd_rd_q ? ST_BUS_REQ : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tmo_expired) begin
          state_d = ST_IDLE;
        end else if (i_RxValid) begin
          data_d = {data_q[23:0], i_RxByte};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS_REQ;
          end
        end
      end
      ST_BUS_REQ: begin
        state_d = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        if (cmd_rd_q) begin
          rdata_d = i_RData;
        end
        status_d   = i_Err ? STS_ERR : STS_OK;
        tx_valid_d = 1'b1;
        cnt_d      = 2'd0;
        state_d    = ST_RESP_STATUS;
      end
      ST_RESP_STATUS: begin
        // Valid drops for one cycle after every handshake before the next byte.
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = (cmd_rd_q && (status_q != STS_BADCMD)) ? ST_RESP_DATA : ST_IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      ST_RESP_DATA: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    overrun_d = i_RxValid && (state_q inside {ST_BUS_REQ, ST_BUS_WAIT, ST_RESP_STATUS, ST_RESP_DATA});
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      cmd_rd_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_rd_q   <= cmd_rd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    tx_byte = status_q;
    if (state_q == ST_RESP_DATA) begin
      case (cnt_q)
        2'd0:    tx_byte = rdata_q[31:24];
        2'd1:    tx_byte = rdata_q[23:16];
        2'd2:    tx_byte = rdata_q[15:8];
        default: tx_byte = rdata_q[7:0];
      endcase
    end
  end

  assign o_TxByte  = tx_byte;
  assign o_TxValid = tx_valid_q;
  assign o_WEnable = (state_q == ST_BUS_REQ) && !cmd_rd_q;
  assign o_REnable = (state_q == ST_BUS_REQ) && cmd_rd_q;
  assign o_WAddr   = addr_q;
  assign o_RAddr   = addr_q;
  assign o_WData   = data_q;
  assign o_Busy    = busy_q;
  assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - self-checking bench for uart_bus_master
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  o_TxByte;
  logic        o_TxValid;
  logic        o_WEnable;
  logic [31:0] o_WAddr;
  logic [31:0] o_WData;
  logic        o_REnable;
  logic [31:0] o_RAddr;
  logic        o_Busy;
  logic        o_Overrun;
  logic [31:0] s_rdata = 32'h0;
  logic        s_err = 1'b0;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_RxByte (rx_byte),
    .i_RxValid(rx_valid),
    .o_TxByte (o_TxByte),
    .o_TxValid(o_TxValid),
    .i_TxReady(tx_ready),
    .o_WEnable(o_WEnable),
    .o_WAddr  (o_WAddr),
    .o_WData  (o_WData),
    .o_REnable(o_REnable),
    .o_RAddr  (o_RAddr),
    .i_RData  (s_rdata),
    .i_Err    (s_err),
    .o_Busy   (o_Busy),
    .o_Overrun(o_Overrun)
  );

  // Registered slave: 16 mapped words at addresses 0..15, everything else errors.
  logic [31:0] slave_mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= 32'h0000_00A5 + (32'(i) << 16);
    end else begin
      if (o_WEnable) begin
        if (o_WAddr < 32'd16) slave_mem[o_WAddr[3:0]] <= o_WData;
        s_err <= (o_WAddr >= 32'd16);
      end
      if (o_REnable) begin
        s_rdata <= (o_RAddr < 32'd16) ? slave_mem[o_RAddr[3:0]] : 32'hDEAD_BEEF;
        s_err   <= (o_RAddr >= 32'd16);
      end
    end
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  exp_sts;
    logic [31:0] exp_rd;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          ovr_count = 0;
  bit          rnd_mode = 1'b0;
  logic [7:0]  exp_tx[$];
  bus_op_t     exp_bus[$];
  logic [31:0] ref_mem [16];
  vec_t        vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock: observe at the falling edge, then move to just after the rising edge.
  task automatic tick();
    bus_op_t     op;
    logic [65:0] got_b, want_b;
    logic [7:0]  e;
    @(negedge clk);
    if (!rst) begin
      if (o_TxValid && tx_ready) begin
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_extra got=%02h want=none", o_TxByte);
        end else begin
          e = exp_tx.pop_front();
          if (o_TxByte !== e) begin
            bad++;
            $display("FAIL tx_byte got=%02h want=%02h", o_TxByte, e);
          end
        end
      end
      if (o_WEnable || o_REnable) begin
        total++;
        if (exp_bus.size() == 0) begin
          bad++;
          $display("FAIL bus_extra we=%0b re=%0b waddr=%08h raddr=%08h", o_WEnable, o_REnable, o_WAddr, o_RAddr);
        end else begin
          op = exp_bus.pop_front();
          if (op.wr) begin
            got_b  = {o_WEnable, o_REnable, o_WAddr, o_WData};
            want_b = {2'b10, op.addr, op.data};
          end else begin
            got_b  = {o_WEnable, o_REnable, o_RAddr, 32'h0};
            want_b = {2'b01, op.addr, 32'h0};
          end
          if (got_b !== want_b) begin
            bad++;
            $display("FAIL bus_op got=%h want=%h", got_b, want_b);
          end
        end
      end
      if (o_Overrun) ovr_count++;
    end
    @(posedge clk);
    #1;
    if (rnd_mode) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data, input bit gaps);
    logic [7:0] bytes[$];
    bytes.push_back(cmd);
    if ((cmd == CMD_WRITE) || (cmd == CMD_READ))
      for (int i = 3; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
    if (cmd == CMD_WRITE)
      for (int i = 3; i >= 0; i--) bytes.push_back(data[8*i +: 8]);
    foreach (bytes[k]) begin
      send_byte(bytes[k]);
      if (gaps) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic push_read_resp(input logic [7:0] sts, input logic [31:0] rd);
    exp_tx.push_back(sts);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
  endtask

  // Reference behaviour: response and bus traffic a frame should produce.
  task automatic model_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    logic mapped;
    mapped = (addr < 32'd16);
    if (cmd == CMD_WRITE) begin
      exp_bus.push_back('{1'b1, addr, data});
      exp_tx.push_back(mapped ? STS_OK : STS_ERR);
      if (mapped) ref_mem[addr[3:0]] = data;
    end else if (cmd == CMD_READ) begin
      exp_bus.push_back('{1'b0, addr, 32'h0});
      push_read_resp(mapped ? STS_OK : STS_ERR, mapped ? ref_mem[addr[3:0]] : 32'hDEAD_BEEF);
    end else begin
      exp_tx.push_back(STS_BADCMD);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (((exp_tx.size() != 0) || o_Busy) && (n < 300)) begin
      tick();
      n++;
    end
    check({name, "_done"}, 64'(((exp_tx.size() != 0) || o_Busy) ? 1 : 0), 64'd0);
    check({name, "_bus_left"}, 64'(exp_bus.size()), 64'd0);
    exp_tx.delete();
    exp_bus.delete();
  endtask

  task automatic init_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0000_00A5 + (32'(i) << 16);
  endtask

  initial begin
    logic [7:0] b0;
    int unstable, ovr0, n;
    logic [7:0] cmd;
    logic [31:0] addr, data;

    vecs[0] = '{CMD_WRITE, 32'h0000_0001, 32'h0000_000F, STS_OK,     32'h0};
    vecs[1] = '{CMD_READ,  32'h0000_0001, 32'h0,         STS_OK,     32'h0000_000F};
    vecs[2] = '{CMD_WRITE, 32'h0000_0005, 32'h1234_5678, STS_OK,     32'h0};
    vecs[3] = '{CMD_READ,  32'h0000_0005, 32'h0,         STS_OK,     32'h1234_5678};
    vecs[4] = '{CMD_READ,  32'h0000_0000, 32'h0,         STS_OK,     32'h0000_00A5};
    vecs[5] = '{CMD_READ,  32'h0000_0100, 32'h0,         STS_ERR,    32'hDEAD_BEEF};
    vecs[6] = '{CMD_WRITE, 32'h0000_0200, 32'hCAFE_0001, STS_ERR,    32'h0};
    vecs[7] = '{8'h33,     32'h0,         32'h0,         STS_BADCMD, 32'h0};

    init_ref();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_tx",    {o_TxValid, o_TxByte}, 64'h0);
    check("rst_bus",   {o_WEnable, o_REnable, o_WAddr}, 64'h0);
    check("rst_wdata", 64'(o_WData), 64'h0);
    check("rst_flags", {o_Busy, o_Overrun}, 64'h0);
    rst = 1'b0;
    tick();

    // Directed table.
    tx_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].cmd == CMD_READ) begin
        exp_bus.push_back('{1'b0, vecs[v].addr, 32'h0});
        push_read_resp(vecs[v].exp_sts, vecs[v].exp_rd);
      end else begin
        if (vecs[v].cmd == CMD_WRITE) begin
          exp_bus.push_back('{1'b1, vecs[v].addr, vecs[v].data});
          if (vecs[v].addr < 32'd16) ref_mem[vecs[v].addr[3:0]] = vecs[v].data;
        end
        exp_tx.push_back(vecs[v].exp_sts);
      end
      send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].data, 1'b1);
      wait_done($sformatf("vec%0d", v));
    end

    // Read latency: strobe at N+1, status valid at N+3.
    exp_bus.push_back('{1'b0, 32'h0, 32'h0});
    push_read_resp(STS_OK, 32'h0000_00A5);
    send_byte(CMD_READ); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check("lat_n1_ren", {o_REnable, o_Busy}, 64'h3);
    tick();
    check("lat_n2", {o_REnable, o_TxValid}, 64'h0);
    tick();
    check("lat_n3", {o_TxValid, o_TxByte}, {55'h0, 1'b1, STS_OK});
    wait_done("latency");

    // Backpressure with an overrun byte during the status phase.
    tx_ready = 1'b0;
    exp_bus.push_back('{1'b0, 32'h1, 32'h0});
    push_read_resp(STS_OK, 32'h0000_000F);
    send_frame(CMD_READ, 32'h1, 32'h0, 1'b0);
    n = 0;
    while (!o_TxValid && n < 20) begin tick(); n++; end
    b0 = o_TxByte;
    check("bp_first", {o_TxValid, b0}, {55'h0, 1'b1, STS_OK});
    unstable = 0;
    ovr0 = ovr_count;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin rx_byte = CMD_WRITE; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
      if (!o_TxValid || (o_TxByte !== b0)) unstable++;
    end
    tick();
    check("bp_stable", 64'(unstable), 64'd0);
    check("bp_overrun", 64'(ovr_count - ovr0), 64'd1);
    tx_ready = 1'b1;
    wait_done("backpressure");

    // Reset while a response is pending.
    tx_ready = 1'b0;
    exp_bus.push_back('{1'b0, 32'h0, 32'h0});
    send_frame(CMD_READ, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (!o_TxValid && n < 20) begin tick(); n++; end
    check("rstmid_pending", 64'(o_TxValid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_cleared", {o_TxValid, o_Busy}, 64'h0);
    tick();
    check("rstmid_after", {o_TxValid, o_Busy}, 64'h0);
    exp_bus.delete();
    init_ref();
    tx_ready = 1'b1;

    // Timeout after a partial frame.
    send_byte(CMD_READ); send_byte(8'h00);
    repeat (TMO - 1) tick();
    check("tmo_not_early", 64'(o_Busy), 64'd1);
    tick();
    check("tmo_idle", 64'(o_Busy), 64'd0);
    wait_done("timeout");

    // Byte on the expiry cycle is discarded without an overrun.
    ovr0 = ovr_count;
    send_byte(CMD_READ); send_byte(8'h00);
    repeat (TMO - 1) tick();
    send_byte(8'h33);
    check("tmo_race_idle", 64'(o_Busy), 64'd0);
    tick(); tick();
    check("tmo_race_noovr", 64'(ovr_count - ovr0), 64'd0);
    wait_done("tmo_race");

    // Random frames against the reference model.
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0: cmd = CMD_WRITE;
        1: cmd = CMD_READ;
        default: begin
          cmd = 8'($urandom);
          if ((cmd == CMD_WRITE) || (cmd == CMD_READ)) cmd = 8'h00;
        end
      endcase
      addr = 32'($urandom_range(0, 19));
      data = $urandom;
      model_frame(cmd, addr, data);
      send_frame(cmd, addr, data, 1'b1);
      wait_done($sformatf("rnd%0d", f));
    end
    rnd_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
